mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bundle for mem_access_unit.
// slave: the access unit itself. master: the pipeline side plus the data memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  // Request channel from the EX/MEM stage.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  // Completion channel.
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;

  // Word-wide, big-endian data memory port.
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output mem_rd, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  mem_rd, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-only, big-endian data memory.
// Sub-word loads are extracted and extended; sub-word stores are done as a
// read-modify-write so the memory only ever sees whole words.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;   // word address, bits [1:0] already cleared
  logic [1:0]        off_q, off_d;       // byte offset within the word
  logic [31:0]       data_q, data_d;     // store data, later the merged word
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_mis_q, resp_mis_d;

  logic              req_misaligned;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  // Classify the incoming request as misaligned or illegal.
  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_size)
      SizeByte: req_misaligned = 1'b0;
      SizeHalf: req_misaligned = bus.req_addr[0];
      SizeWord: req_misaligned = |bus.req_addr[1:0];
      default:  req_misaligned = 1'b1;
    endcase
  end

  // Select the addressed byte/halfword lane from the big-endian memory word.
  always_comb begin
    rd_byte = bus.mem_rdata[31:24];
    case (off_q)
      2'd0:    rd_byte = bus.mem_rdata[31:24];
      2'd1:    rd_byte = bus.mem_rdata[23:16];
      2'd2:    rd_byte = bus.mem_rdata[15:8];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
  end

  // Sign- or zero-extend the extracted lane into the load result.
  always_comb begin
    load_ext = bus.mem_rdata;
    case (size_q)
      SizeByte: load_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SizeHalf: load_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default:  load_ext = bus.mem_rdata;
    endcase
  end

  // Overlay the right-justified store data onto the addressed lanes of the read word.
  always_comb begin
    merged = bus.mem_rdata;
    if (size_q == SizeByte) begin
      case (off_q)
        2'd0:    merged[31:24] = data_q[7:0];
        2'd1:    merged[23:16] = data_q[7:0];
        2'd2:    merged[15:8]  = data_q[7:0];
        default: merged[7:0]   = data_q[7:0];
      endcase
    end else if (size_q == SizeHalf) begin
      if (off_q[1]) begin
        merged[15:0] = data_q[15:0];
      end else begin
        merged[31:16] = data_q[15:0];
      end
    end
  end

  // Next-state logic: accept in IDLE, sequence RD/WR, one-cycle RESP.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    waddr_d      = waddr_q;
    off_d        = off_q;
    data_d       = data_q;
    // Response registers are live only for the RESP cycle, so they default to 0.
    resp_rdata_d = '0;
    resp_mis_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          waddr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
          off_d   = bus.req_addr[1:0];
          data_d  = bus.req_wdata;
          if (req_misaligned) begin
            resp_mis_d = 1'b1;
            state_d    = StResp;
          end else if (bus.req_we && (bus.req_size == SizeWord)) begin
            state_d = StWr;
          end else begin
            // Loads, and sub-word stores that need the old word first.
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (we_q) begin
          data_d  = merged;
          state_d = StWr;
        end else begin
          resp_rdata_d = load_ext;
          state_d      = StResp;
        end
      end
      StWr: begin
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched request fields; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      waddr_q      <= '0;
      off_q        <= 2'b00;
      data_q       <= '0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      waddr_q      <= waddr_d;
      off_q        <= off_d;
      data_q       <= data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
    end
  end

  // Outputs decoded only from registered state, never from req_* inputs.
  always_comb begin
    bus.req_ready       = (state_q == StIdle);
    bus.mem_rd          = (state_q == StRd);
    bus.mem_raddr       = (state_q == StRd) ? waddr_q : '0;
    bus.mem_we          = (state_q == StWr);
    bus.mem_waddr       = (state_q == StWr) ? waddr_q : '0;
    bus.mem_wdata       = (state_q == StWr) ? data_q : '0;
    bus.resp_valid      = (state_q == StResp);
    bus.resp_rdata      = resp_rdata_q;
    bus.resp_misaligned = resp_mis_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues requests and pushes the
// expected outcome from a word-array reference model; a monitor on the falling
// edge follows each access and compares when the response arrives.
module tb_mem_access_unit;

  localparam int unsigned AW = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          nrd;
    int          nwe;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  logic clk;
  logic reset;

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  exp_t        exp_q   [$];

  int n_cmp;
  int n_err;

  // Monitor state.
  logic        in_txn;
  int          cyc;
  int          n_rd;
  int          n_we;
  logic [7:0]  seen_waddr;
  logic [31:0] seen_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational big-endian read, write on the clock edge.
  assign bus.mem_rdata = mem[bus.mem_raddr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr[7:2]] <= bus.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: result of one access against the model memory.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd, output exp_t e);
    logic [31:0] w, mask, v;
    int          off, nbits, sh;
    w      = ref_mem[a[7:2]];
    off    = int'(a[1:0]);
    e.addr = {a[7:2], 2'b00};
    e.rdata = 0; e.mis = 0; e.nrd = 0; e.nwe = 0; e.wdata = 0; e.lat = 0;
    if (size == 2'd3 || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 0)) begin
      e.mis = 1; e.lat = 1;
    end else if (size == 2'd2) begin
      e.lat = 2;
      if (we) begin
        e.nwe = 1; e.wdata = wd; ref_mem[a[7:2]] = wd;
      end else begin
        e.nrd = 1; e.rdata = w;
      end
    end else begin
      nbits = (size == 2'd0) ? 8 : 16;
      mask  = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
      sh    = 32 - nbits - 8 * off;
      e.nrd = 1;
      if (we) begin
        e.lat   = 3;
        e.nwe   = 1;
        e.wdata = (w & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[a[7:2]] = e.wdata;
      end else begin
        e.lat = 2;
        v = (w >> sh) & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        e.rdata = v;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
  endtask

  // Issue one request once ready; use_lit pins the expected rdata (load) or wdata (store).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] a, input logic [31:0] wd,
                       input logic use_lit, input logic [31:0] lit);
    exp_t e;
    int   waitc;
    waitc = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!bus.req_ready) begin
      check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
      return;
    end
    model(we, size, uns, a, wd, e);
    if (use_lit) begin
      if (we) e.wdata = lit;
      else    e.rdata = lit;
    end
    exp_q.push_back(e);
    drive(we, size, uns, a, wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each response.
  initial begin
    exp_t e;
    in_txn = 1'b0; cyc = 0; n_rd = 0; n_we = 0; seen_waddr = 0; seen_wdata = 0;
    forever begin
      @(negedge clk);
      if (!reset) in_txn = 1'b0;
      if (!bus.resp_valid) begin
        check("idle_rdata", bus.resp_rdata, 32'd0);
        check("idle_misaligned", {31'b0, bus.resp_misaligned}, 32'd0);
      end
      if (!bus.mem_rd) check("idle_raddr", {24'b0, bus.mem_raddr}, 32'd0);
      if (!bus.mem_we) check("idle_wport", {24'b0, bus.mem_waddr} | bus.mem_wdata, 32'd0);
      if (in_txn) begin
        cyc++;
        if (bus.mem_rd) begin
          n_rd++;
          if (exp_q.size() > 0) check("mem_raddr", {24'b0, bus.mem_raddr}, {24'b0, exp_q[0].addr});
        end
        if (bus.mem_we) begin
          n_we++;
          seen_waddr = bus.mem_waddr;
          seen_wdata = bus.mem_wdata;
        end
        if (bus.resp_valid) begin
          in_txn = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_misaligned", {31'b0, bus.resp_misaligned}, {31'b0, e.mis});
            check("resp_latency", 32'(cyc), 32'(e.lat));
            check("mem_rd_cycles", 32'(n_rd), 32'(e.nrd));
            check("mem_we_cycles", 32'(n_we), 32'(e.nwe));
            if (e.nwe > 0) begin
              check("mem_waddr", {24'b0, seen_waddr}, {24'b0, e.addr});
              check("mem_wdata", seen_wdata, e.wdata);
            end
          end
        end else if (cyc > 8) begin
          check("resp_timeout", 32'd0, 32'd1);
          in_txn = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else begin
        check("stray_activity", {29'b0, bus.mem_rd, bus.mem_we, bus.resp_valid}, 32'd0);
      end
      // Request visible while ready: it is taken on the coming rising edge.
      if (reset && !in_txn && bus.req_valid && bus.req_ready) begin
        in_txn = 1'b1; cyc = 0; n_rd = 0; n_we = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [1:0]  sz;
    int          waitc;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h0000_F1FF; ref_mem[0] = 32'h0000_F1FF;
    mem[2] = 32'h0109_60A4; ref_mem[2] = 32'h0109_60A4;

    // Reset values, with a request already waiting on the bus.
    #3;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_outputs", {29'b0, bus.resp_valid, bus.mem_rd, bus.mem_we}, 32'd0);
    check("rst_data", bus.resp_rdata | bus.mem_wdata, 32'd0);
    check("rst_addrs", {16'b0, bus.mem_raddr, bus.mem_waddr}, 32'd0);
    model(1'b0, 2'd0, 1'b0, 8'd2, 32'd0, e);
    e.rdata = 32'hFFFF_FFF1;
    exp_q.push_back(e);
    drive(1'b0, 2'd0, 1'b0, 8'd2, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    // The very first edge after release must take the request.
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    // Directed accesses on the two preset words.
    issue(1'b0, 2'd0, 1'b1, 8'd2,  32'd0,          1'b1, 32'h0000_00F1);
    issue(1'b0, 2'd1, 1'b0, 8'd10, 32'd0,          1'b1, 32'h0000_60A4);
    issue(1'b0, 2'd1, 1'b0, 8'd8,  32'd0,          1'b1, 32'h0000_0109);
    issue(1'b1, 2'd0, 1'b0, 8'd9,  32'h0000_00AB,  1'b1, 32'h01AB_60A4);
    issue(1'b1, 2'd2, 1'b0, 8'd12, 32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 8'd6,  32'd0,          1'b1, 32'd0);
    issue(1'b1, 2'd1, 1'b0, 8'd3,  32'h1234_5678,  1'b0, 32'd0);
    issue(1'b0, 2'd3, 1'b0, 8'd0,  32'd0,          1'b1, 32'd0);

    // Reset during the read phase of a halfword store: nothing may be written.
    @(posedge clk); #1;
    while (!bus.req_ready) begin @(posedge clk); #1; end
    drive(1'b1, 2'd1, 1'b0, 8'd20, 32'h0000_5A5A);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rmw_mem_rd_before_reset", {31'b0, bus.mem_rd}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_mem_rd_drop", {30'b0, bus.mem_rd, bus.mem_we}, 32'd0);
    check("async_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("post_reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(posedge clk);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), $urandom, 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Drain, then the memory image must match the model.
    waitc = 0;
    while ((exp_q.size() != 0 || in_txn) && waitc < 50) begin
      @(posedge clk);
      waitc++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) check("mem_image", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
